// File: rtl/pc_file_vec.sv
// Per-thread program-counter file: one PC per hardware thread in LUT RAM, self-initialised
// to per-thread start addresses after reset, with pipeline writeback and a redirect port.
module pc_file_vec #(
    parameter int unsigned NUM_THREADS  = 16,
    parameter int unsigned PC_WIDTH     = 12,
    parameter int unsigned XLEN         = 32,
    parameter int unsigned STARTUP_ADDR = 0,
    parameter int unsigned ADDR_STRIDE  = 0,
    localparam int unsigned TW          = $clog2(NUM_THREADS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [TW-1:0]   i_thread_index_counter,
    input  logic [TW-1:0]   i_thread_index_execute,
    input  logic            i_pc_we,
    input  logic [XLEN-1:0] i_pc_in,
    input  logic            i_ext_wr_valid,
    input  logic [TW-1:0]   i_ext_wr_thread,
    input  logic [XLEN-1:0] i_ext_wr_pc,
    output logic            o_ext_wr_ready,
    output logic            o_init_done,
    output logic [XLEN-1:0] o_pcreg_out
);

    typedef enum logic {INIT, RUN} state_t;

    state_t                state_reg, state_next;
    logic [TW-1:0]         init_idx_reg, init_idx_next;
    logic                  wr_valid_reg, wr_valid_next;
    logic [TW-1:0]         wr_thread_reg, wr_thread_next;
    logic [PC_WIDTH-1:0]   wr_data_reg, wr_data_next;

    logic [PC_WIDTH-1:0]   mem [NUM_THREADS];
    logic [PC_WIDTH-1:0]   start_pc [NUM_THREADS];
    logic                  mem_we;
    logic [TW-1:0]         mem_waddr;
    logic [PC_WIDTH-1:0]   mem_wdata;
    logic [PC_WIDTH-1:0]   rd_data;
    logic                  run;
    logic                  ext_ready;
    logic                  unused_pc_hi;

    // Start addresses are computed in PC_WIDTH arithmetic so they wrap like the stored PC.
    generate
        for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_start
            assign start_pc[gi] = PC_WIDTH'(STARTUP_ADDR) + PC_WIDTH'(ADDR_STRIDE) * PC_WIDTH'(gi);
        end
    endgenerate

    assign run = (state_reg == RUN);

    // A redirect loses only to a pipeline write aimed at a different thread.
    assign ext_ready = run && i_ext_wr_valid &&
                       (!i_pc_we || (i_ext_wr_thread == i_thread_index_execute));

    always_comb begin
        state_next     = state_reg;
        init_idx_next  = init_idx_reg;
        wr_valid_next  = 1'b0;
        wr_thread_next = wr_thread_reg;
        wr_data_next   = wr_data_reg;
        case (state_reg)
            INIT: begin
                init_idx_next = init_idx_reg + TW'(1);
                if (init_idx_reg == TW'(NUM_THREADS - 1)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (ext_ready) begin
                    wr_valid_next  = 1'b1;
                    wr_thread_next = i_ext_wr_thread;
                    wr_data_next   = i_ext_wr_pc[PC_WIDTH-1:0];
                end else if (i_pc_we) begin
                    wr_valid_next  = 1'b1;
                    wr_thread_next = i_thread_index_execute;
                    wr_data_next   = i_pc_in[PC_WIDTH-1:0];
                end
            end
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= INIT;
            init_idx_reg  <= '0;
            wr_valid_reg  <= 1'b0;
            wr_thread_reg <= '0;
            wr_data_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            init_idx_reg  <= init_idx_next;
            wr_valid_reg  <= wr_valid_next;
            wr_thread_reg <= wr_thread_next;
            wr_data_reg   <= wr_data_next;
        end
    end

    // RAM port: init sweep while in INIT, write-stage register afterwards.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_thread_reg;
        mem_wdata = wr_data_reg;
        if (!run) begin
            mem_we    = 1'b1;
            mem_waddr = init_idx_reg;
            mem_wdata = start_pc[init_idx_reg];
        end else if (wr_valid_reg) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        if (!run) begin
            rd_data = start_pc[i_thread_index_counter];
        end else if (wr_valid_reg && (wr_thread_reg == i_thread_index_counter)) begin
            rd_data = wr_data_reg;
        end else begin
            rd_data = mem[i_thread_index_counter];
        end
    end

    assign o_pcreg_out    = XLEN'(rd_data);
    assign o_ext_wr_ready = ext_ready;
    assign o_init_done    = run;

    // Upper PC bits are intentionally discarded.
    assign unused_pc_hi = ^{i_pc_in, i_ext_wr_pc};

endmodule

// File: doc/pc_file_vec.md
# pc_file_vec

Per-thread program-counter file for the barrel-threaded core; parametrised successor to the fixed 12-bit, 8/16-thread PC store. Holds one PC per hardware thread in distributed (LUT) RAM, self-initialises every entry to a per-thread start address after reset, and accepts the execute-stage PC writeback each cycle. Adds an external redirect port with a valid/ready handshake and a same-cycle read bypass. Sits between the execute-stage PC update and the fetch-stage thread counter.

## Interface
- NUM_THREADS, 16: thread count; power of two, 2..64; TW = $clog2(NUM_THREADS).
- PC_WIDTH, 12: stored PC bits, 2..XLEN.
- XLEN, 32: output PC width.
- STARTUP_ADDR, 0: start PC of thread 0.
- ADDR_STRIDE, 0: start-PC offset between consecutive threads; thread t starts at STARTUP_ADDR + t*ADDR_STRIDE, truncated to PC_WIDTH.

- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_thread_index_counter  in  TW  fetch read address (thread being fetched).
- i_thread_index_execute  in  TW  pipeline write thread.
- i_pc_we  in  1  pipeline write valid.
- i_pc_in  in  XLEN  next PC from execute; bits [PC_WIDTH-1:0] stored.
- i_ext_wr_valid  in  1  redirect request.
- i_ext_wr_thread  in  TW  redirect target thread.
- i_ext_wr_pc  in  XLEN  redirect PC; bits [PC_WIDTH-1:0] stored.
- o_ext_wr_ready  out  1  redirect accepted this cycle.
- o_init_done  out  1  all entries initialised; file in RUN.
- o_pcreg_out  out  XLEN  PC of i_thread_index_counter, zero-extended.

## Operation
- FSM states: INIT, RUN. Reset forces INIT, init index = 0, write stage valid = 0.
- INIT: each cycle writes start PC of init index to RAM, increments index; after writing index NUM_THREADS-1 moves to RUN. Pipeline writes and redirects ignored; o_ext_wr_ready = 0.
- INIT read: o_pcreg_out = start PC of i_thread_index_counter (computed, not from RAM); output valid from reset.
- RUN write selection, per cycle:
  - redirect only: redirect accepted (ready = 1), write (thread, pc) from redirect.
  - pipeline only: write pipeline (thread, pc).
  - both, same thread: redirect wins, ready = 1, pipeline value discarded.
  - both, different threads: pipeline wins, ready = 0; requester holds valid/thread/pc until ready.
- Selected write captured in a write-stage register (valid, thread, data); RAM written from this register on the next edge.
- Read: RAM asynchronous read at i_thread_index_counter; if write-stage valid and its thread equals read address, write-stage data bypasses RAM.
- Width: stored value = low PC_WIDTH bits; output = {XLEN-PC_WIDTH zeros, stored}. Start-address arithmetic done in PC_WIDTH bits, wraps modulo 2^PC_WIDTH.
- Reset mid-RUN or mid-INIT: immediate return to INIT index 0; pending write-stage entry dropped; full re-init follows.

## Timing
- Reset values: o_init_done = 0, o_ext_wr_ready = 0, o_pcreg_out = start PC of addressed thread.
- INIT lasts exactly NUM_THREADS cycles after reset deassertion; o_init_done rises at the edge ending the last init write.
- Write latency: write presented in cycle k is visible on o_pcreg_out in cycle k+1 (bypass), in RAM from cycle k+2.
- o_ext_wr_ready is combinational from current inputs and state; transfer occurs on edge where valid & ready.
- Read path purely combinational; no read latency.

## Test plan
- Reset, NUM_THREADS=16, STARTUP_ADDR=0x100, ADDR_STRIDE=0x40, sweep read address during and after INIT -> thread t reads 0x100+0x40*t throughout; o_init_done rises after 16 cycles.
- RUN, i_pc_we=1 thread 3 pc 0x0000_1A24, read thread 3 next cycle and two cycles later -> 0x0000_0A24 both times (PC_WIDTH=12 truncation, bypass then RAM).
- Same cycle pipeline thread 5 pc 0x200 and redirect thread 5 pc 0x300 -> ready=1, thread 5 reads 0x300.
- Same cycle pipeline thread 2 pc 0x204, redirect thread 7 pc 0x500 held -> ready=0 that cycle; next cycle with i_pc_we=0 ready=1; thread 2 = 0x204, thread 7 = 0x500.
- Redirect asserted during INIT -> ready=0 until o_init_done=1; entry unchanged by request until accepted.
- Reset asserted mid-RUN after writes to threads 0..3 -> o_init_done falls asynchronously, all threads read start PCs, pending write not committed.
